uart_rx: RTL and testbench

- UART receiver that deserializes the asynchronous serial line into bytes.
- Sits directly upstream of the command decoder and the RX FIFO: it drives `rx_data` and `rx_done`.
- Format is 8N1, LSB first, with 16x oversampling from an internal baud tick generator.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_if.sv | 30 +++
 rtl/baud_tick_gen.sv | 34 +++
 rtl/uart_rx.sv | 132 +++++++++++++
 tb/tb_uart_rx.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART blocks: FSM encodings, oversampling ratio, divider math.
// Latency: n/a (compile-time constants and a constant function only).
// Backpressure: n/a.
package uart_pkg;

  // Receiver FSM encodings, kept as plain 2-bit constants for legacy tools
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Ticks per bit and the tick index that lands in the middle of the start bit
  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_START  = 4'd7;

  // Clocks per oversample tick, truncated; 100 MHz / 9600 baud gives 651
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bundle: serial line in, parallel byte and status strobes out.
// Latency: n/a (wires only).
// Backpressure: none; the consumer must take rx_data on the rx_done pulse.
interface uart_rx_if;

  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  // Receiver side: samples the line, drives the byte and strobes
  modport master (
    input  rx,
    output rx_data,
    output rx_done,
    output rx_busy,
    output frame_err
  );

  // Line driver / consumer side
  modport slave (
    output rx,
    input  rx_data,
    input  rx_done,
    input  rx_busy,
    input  frame_err
  );

endinterface

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick generator: one-clk tick every baud_div(CLK_FREQ, BAUD) clocks.
// Latency: first tick DIV clocks after reset release; period exactly DIV clocks thereafter.
// Backpressure: none; the counter never stalls and is cleared only by reset.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int             DIV  = baud_div(CLK_FREQ, BAUD);
  localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 and wrap; the wrap cycle is the tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, 16x oversampled, mid-bit sampling.
// Latency: rx_done ~9.5 bit times after the start edge, plus 2 clk of synchronizer delay.
// Backpressure: none; rx_data holds until the next good frame, consumer samples on rx_done.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  // Last tick index of a full bit; mid-bit for data/stop since counting starts mid start bit
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  logic       tick;
  logic       rx_meta;
  logic       rx_s;
  logic [1:0] state;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] rx_data_q;
  logic       rx_done_q;
  logic       frame_err_q;

  baud_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchronizer; resets to the idle (high) line level so reset never looks like a start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM: qualify start at mid bit, then sample every 16 ticks; strobes default low each clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      tick_cnt    <= 4'd0;
      bit_cnt     <= 3'd0;
      shift       <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= 4'd0;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == MID_START) begin
              if (!rx_s) begin
                state    <= DATA;
                tick_cnt <= 4'd0;
                bit_cnt  <= 3'd0;
              end else begin
                // Line went back high before mid start bit: a glitch, not a frame
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == LAST_TICK) begin
              shift[bit_cnt] <= rx_s;
              tick_cnt       <= 4'd0;
              if (bit_cnt == 3'd7) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt == LAST_TICK) begin
              if (rx_s) begin
                rx_data_q <= shift;
                rx_done_q <= 1'b1;
              end else begin
                // Bad stop bit: flag it and keep the previously delivered byte
                frame_err_q <= 1'b1;
              end
              // Re-arm now so a start edge right after the stop midpoint is caught
              state    <= IDLE;
              tick_cnt <= 4'd0;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Busy only once the start bit has been qualified, so short glitches never show as activity
  assign bus.rx_busy   = (state == DATA) || (state == STOP);
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 115200 baud (DIV=54, 864 clk per bit).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 115200;
  localparam int BIT      = 864;

  typedef struct {
    logic [7:0] d;
    int         stop_low;
    int         gap;
    logic [7:0] exp_data;
    int         exp_done;
    int         exp_err;
    bit         chk_lat;
    bit         chk_gap;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc       = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  int busy_cnt  = 0;
  int both_cnt  = 0;
  int last_done = 0;
  int prev_done = 0;
  int start_cyc = 0;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (bus.rx_done === 1'b1) begin
      done_cnt  <= done_cnt + 1;
      prev_done <= last_done;
      last_done <= cyc;
    end
    if (bus.frame_err === 1'b1) err_cnt <= err_cnt + 1;
    if (bus.rx_busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (bus.rx_done === 1'b1 && bus.frame_err === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Hold the line at v for n clocks; called and returns on a falling edge
  task automatic drive(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame; stop_low > 0 holds the stop bit low for that many clocks, through its midpoint
  task automatic send_frame(input logic [7:0] d, input int stop_low);
    start_cyc = cyc;
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(d[i], BIT);
    if (stop_low > 0) begin
      drive(1'b0, stop_low);
      drive(1'b1, BIT - stop_low);
    end else begin
      drive(1'b1, BIT);
    end
  endtask

  vec_t       vecs [4];
  int         d0, e0, b0;
  logic [7:0] pat;

  initial begin
    vecs[0] = '{8'h72, 0,   100, 8'h72, 1, 0, 1'b1, 1'b0};
    vecs[1] = '{8'h6D, 0,   100, 8'h6D, 1, 0, 1'b0, 1'b0};
    vecs[2] = '{8'h63, 0,   0,   8'h63, 1, 0, 1'b0, 1'b1};
    vecs[3] = '{8'hA5, 600, 100, 8'h63, 0, 1, 1'b0, 1'b0};

    // Reset state
    bus.rx = 1'b1;
    rst    = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_rx_done", bus.rx_done, 1'b0);
    check("rst_rx_busy", bus.rx_busy, 1'b0);
    check("rst_frame_err", bus.frame_err, 1'b0);

    // Idle line after release: nothing happens
    rst = 1'b1;
    d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
    repeat (20000) @(negedge clk);
    check("idle_done", done_cnt - d0, 0);
    check("idle_err", err_cnt - e0, 0);
    check("idle_busy", busy_cnt - b0, 0);
    check("idle_rx_data", bus.rx_data, 8'h00);

    // Frame table: good frame, back-to-back pair, bad stop bit
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vecs[i].gap);
      d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
      send_frame(vecs[i].d, vecs[i].stop_low);
      check($sformatf("vec%0d_data", i), bus.rx_data, vecs[i].exp_data);
      check($sformatf("vec%0d_done", i), done_cnt - d0, vecs[i].exp_done);
      check($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].exp_err);
      check($sformatf("vec%0d_busy_seen", i), (busy_cnt - b0) > 0, 1'b1);
      if (vecs[i].chk_lat)
        check_range($sformatf("vec%0d_latency", i), last_done - start_cyc, 8208 - 60, 8208 + 60);
      if (vecs[i].chk_gap)
        check_range($sformatf("vec%0d_spacing", i), last_done - prev_done, 8640 - 54, 8640 + 54);
    end

    // 300-clk low glitch on an idle line
    drive(1'b1, 1000);
    d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
    drive(1'b0, 300);
    drive(1'b1, 2000);
    check("glitch_done", done_cnt - d0, 0);
    check("glitch_err", err_cnt - e0, 0);
    check("glitch_busy", busy_cnt - b0, 0);
    check("glitch_rx_data", bus.rx_data, 8'h63);

    // Reset in the middle of data bit 4 of 0x55, then a clean 0x3C
    drive(1'b1, 500);
    d0 = done_cnt; e0 = err_cnt;
    pat = 8'h55;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(pat[i], BIT);
    drive(pat[4], BIT / 2);
    check("abort_busy_before", bus.rx_busy, 1'b1);
    rst    = 1'b0;
    bus.rx = 1'b1;
    #1;
    check("abort_busy_async", bus.rx_busy, 1'b0);
    check("abort_data_async", bus.rx_data, 8'h00);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 2000);
    check("abort_done", done_cnt - d0, 0);
    check("abort_err", err_cnt - e0, 0);
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h3C, 0);
    check("after_abort_data", bus.rx_data, 8'h3C);
    check("after_abort_done", done_cnt - d0, 1);
    check("after_abort_err", err_cnt - e0, 0);

    check("done_err_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
